// File: rtl/data_latch_pkg.sv
// Shared definitions for the start-token word-latch interface.
// Used by the transmit side (data_unlatch_tx) and the receive-side latch array.
//  - state_e : frame sequencer states
//  - cnt_w() : counter width helper, max(1, $clog2(n))
package data_latch_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        LEAD_WAIT = 3'd2,
        SEND      = 3'd3,
        DONE      = 3'd4
    } state_e;

    // A counter over n values never gets narrower than one bit, even when n==1.
    function automatic int cnt_w(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/data_unlatch_tx.sv
// data_unlatch_tx: snapshots STAGE parallel words and replays them serially,
// one word per clk, LEAD cycles after a one-cycle start pulse.
// Ports:
//  clk, rst        clock (posedge) and asynchronous active-high reset
//  load_valid/ready frame handshake: a frame is taken on the rising clk edge
//                  where both are high; ready is high only in IDLE
//  data_in         STAGE words, [0] sent first; sampled only at the accept edge
//  start_o         one-cycle frame start pulse
//  data_o/data_vld serial word and its qualifier; data_o is zero when not valid
//  busy            high from the cycle after accept through the last word
//  done            one-cycle pulse in the cycle after the last word
//  dbg_state       current sequencer state (state_e encoding)
module data_unlatch_tx
    import data_latch_pkg::*;
#(
    parameter int STAGE  = 8,
    parameter int DWIDTH = 8,
    parameter int LEAD   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [DWIDTH-1:0] data_in [0:STAGE-1],
    output logic              start_o,
    output logic [DWIDTH-1:0] data_o,
    output logic              data_vld,
    output logic              busy,
    output logic              done,
    output logic [2:0]        dbg_state
);

    localparam int IW = cnt_w(STAGE);
    localparam int LW = cnt_w(LEAD);
    localparam logic [IW-1:0] IDX_LAST  = IW'(STAGE - 1);
    // LEAD_WAIT spans LEAD-1 cycles, counted 0..LEAD-2; unused when LEAD==1.
    localparam logic [LW-1:0] LEAD_LAST = LW'((LEAD > 1) ? (LEAD - 2) : 0);

    state_e            state_q, state_d;
    logic [DWIDTH-1:0] frame_q [0:STAGE-1];
    logic [DWIDTH-1:0] frame_d [0:STAGE-1];
    logic [IW-1:0]     idx_q, idx_d;
    logic [LW-1:0]     lead_q, lead_d;

    logic              start_q, start_d;
    logic [DWIDTH-1:0] data_q, data_d;
    logic              vld_q, vld_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // Sequencer and buffer next-state.
    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        idx_d   = idx_q;
        lead_d  = lead_q;
        case (state_q)
            IDLE: begin
                if (load_valid) begin
                    frame_d = data_in;
                    idx_d   = '0;
                    lead_d  = '0;
                    state_d = START;
                end
            end
            START: begin
                lead_d = '0;
                if (LEAD > 1) state_d = LEAD_WAIT;
                else          state_d = SEND;
            end
            LEAD_WAIT: begin
                if (lead_q == LEAD_LAST) state_d = SEND;
                else                     lead_d  = lead_q + LW'(1);
            end
            SEND: begin
                if (idx_q == IDX_LAST) begin
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are computed from the next state so that every output except
    // load_ready comes straight from a flop.
    always_comb begin
        start_d = (state_d == START);
        vld_d   = (state_d == SEND);
        busy_d  = (state_d == START) || (state_d == LEAD_WAIT) || (state_d == SEND);
        done_d  = (state_d == DONE);
        data_d  = vld_d ? frame_d[idx_d] : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            for (int i = 0; i < STAGE; i++) frame_q[i] <= '0;
            idx_q   <= '0;
            lead_q  <= '0;
            start_q <= 1'b0;
            data_q  <= '0;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            idx_q   <= idx_d;
            lead_q  <= lead_d;
            start_q <= start_d;
            data_q  <= data_d;
            vld_q   <= vld_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign load_ready = (state_q == IDLE);
    assign start_o    = start_q;
    assign data_o     = data_q;
    assign data_vld   = vld_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_data_unlatch_tx.sv
module tb_data_unlatch_tx;

    logic clk;
    logic rst;

    // DUT A: defaults (STAGE=8, DWIDTH=8, LEAD=1)
    logic       lv_a, lr_a, st_a, vld_a, busy_a, done_a;
    logic [7:0] din_a [0:7];
    logic [7:0] do_a;
    logic [2:0] dbg_a;

    // DUT B: STAGE=2, DWIDTH=8, LEAD=3
    logic       lv_b, lr_b, st_b, vld_b, busy_b, done_b;
    logic [7:0] din_b [0:1];
    logic [7:0] do_b;
    logic [2:0] dbg_b;

    // DUT C: STAGE=1, DWIDTH=16, LEAD=1
    logic        lv_c, lr_c, st_c, vld_c, busy_c, done_c;
    logic [15:0] din_c [0:0];
    logic [15:0] do_c;
    logic [2:0]  dbg_c;

    int n_checks;
    int n_errors;

    data_unlatch_tx u_a (
        .clk(clk), .rst(rst), .load_valid(lv_a), .load_ready(lr_a), .data_in(din_a),
        .start_o(st_a), .data_o(do_a), .data_vld(vld_a), .busy(busy_a), .done(done_a),
        .dbg_state(dbg_a)
    );

    data_unlatch_tx #(.STAGE(2), .DWIDTH(8), .LEAD(3)) u_b (
        .clk(clk), .rst(rst), .load_valid(lv_b), .load_ready(lr_b), .data_in(din_b),
        .start_o(st_b), .data_o(do_b), .data_vld(vld_b), .busy(busy_b), .done(done_b),
        .dbg_state(dbg_b)
    );

    data_unlatch_tx #(.STAGE(1), .DWIDTH(16), .LEAD(1)) u_c (
        .clk(clk), .rst(rst), .load_valid(lv_c), .load_ready(lr_c), .data_in(din_c),
        .start_o(st_c), .data_o(do_c), .data_vld(vld_c), .busy(busy_c), .done(done_c),
        .dbg_state(dbg_c)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to the next cycle and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver / frame tasks ----------------
    // Accept one frame on DUT A and check every cycle up to IDLE again.
    task automatic frame_a(input logic [7:0] w [0:7]);
        din_a = w;
        lv_a  = 1'b1;
        tick();                               // cycle E+1
        lv_a  = 1'b0;
        for (int k = 0; k < 8; k++) din_a[k] = 8'hFF;
        check_eq("a_start", {31'd0, st_a}, 32'd1);
        check_eq("a_busy_start", {31'd0, busy_a}, 32'd1);
        check_eq("a_vld_start", {31'd0, vld_a}, 32'd0);
        check_eq("a_data_start", {24'd0, do_a}, 32'd0);
        check_eq("a_ready_start", {31'd0, lr_a}, 32'd0);
        for (int k = 0; k < 8; k++) begin
            tick();                           // cycle E+2+k
            check_eq("a_word", {24'd0, do_a}, {24'd0, w[k]});
            check_eq("a_vld", {31'd0, vld_a}, 32'd1);
            check_eq("a_start_low", {31'd0, st_a}, 32'd0);
            check_eq("a_busy_send", {31'd0, busy_a}, 32'd1);
        end
        tick();                               // cycle E+10
        check_eq("a_done", {31'd0, done_a}, 32'd1);
        check_eq("a_busy_done", {31'd0, busy_a}, 32'd0);
        check_eq("a_vld_done", {31'd0, vld_a}, 32'd0);
        check_eq("a_data_done", {24'd0, do_a}, 32'd0);
        check_eq("a_ready_done", {31'd0, lr_a}, 32'd0);
        tick();                               // cycle E+11
        check_eq("a_ready_idle", {31'd0, lr_a}, 32'd1);
        check_eq("a_done_low", {31'd0, done_a}, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] w [0:7];
        n_checks = 0;
        n_errors = 0;
        lv_a = 1'b0; lv_b = 1'b0; lv_c = 1'b0;
        for (int k = 0; k < 8; k++) din_a[k] = '0;
        din_b[0] = '0; din_b[1] = '0;
        din_c[0] = '0;

        // 1: reset held 3 cycles
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check_eq("rst_ready_a", {31'd0, lr_a}, 32'd1);
        check_eq("rst_ready_b", {31'd0, lr_b}, 32'd1);
        check_eq("rst_ready_c", {31'd0, lr_c}, 32'd1);
        check_eq("rst_start_a", {31'd0, st_a}, 32'd0);
        check_eq("rst_data_a", {24'd0, do_a}, 32'd0);
        check_eq("rst_vld_a", {31'd0, vld_a}, 32'd0);
        check_eq("rst_busy_a", {31'd0, busy_a}, 32'd0);
        check_eq("rst_done_a", {31'd0, done_a}, 32'd0);
        check_eq("rst_state_a", {29'd0, dbg_a}, 32'd0);

        // 2: default frame 11..88
        w = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        frame_a(w);

        // 3: DUT B, LEAD=3 STAGE=2, A5 5A
        din_b[0] = 8'hA5; din_b[1] = 8'h5A;
        lv_b = 1'b1;
        tick();                               // E+1
        lv_b = 1'b0;
        din_b[0] = 8'h00; din_b[1] = 8'h00;
        check_eq("b_start", {31'd0, st_b}, 32'd1);
        check_eq("b_busy", {31'd0, busy_b}, 32'd1);
        for (int c = 2; c <= 3; c++) begin
            tick();                           // E+2, E+3 lead wait
            check_eq("b_lead_start", {31'd0, st_b}, 32'd0);
            check_eq("b_lead_vld", {31'd0, vld_b}, 32'd0);
            check_eq("b_lead_busy", {31'd0, busy_b}, 32'd1);
        end
        tick();                               // E+4
        check_eq("b_word0", {24'd0, do_b}, 32'hA5);
        check_eq("b_vld0", {31'd0, vld_b}, 32'd1);
        tick();                               // E+5
        check_eq("b_word1", {24'd0, do_b}, 32'h5A);
        tick();                               // E+6
        check_eq("b_done", {31'd0, done_b}, 32'd1);
        check_eq("b_data_done", {24'd0, do_b}, 32'd0);
        tick();                               // E+7
        check_eq("b_ready", {31'd0, lr_b}, 32'd1);

        // 4: load_valid held high, data_in changing every cycle.
        // In cycle t, data_in[k] = t*16+k+1; frame f is captured in cycle 11f.
        for (int k = 0; k < 8; k++) din_a[k] = 8'(k + 1);
        lv_a = 1'b1;
        for (int t = 1; t <= 33; t++) begin
            int ph;
            int f;
            tick();
            ph = t % 11;
            f  = (t - 1) / 11;
            if (ph == 1) begin
                check_eq("bb_start", {31'd0, st_a}, 32'd1);
            end else if (ph >= 2 && ph <= 9) begin
                check_eq("bb_word", {24'd0, do_a}, {24'd0, 8'(176 * f + (ph - 2) + 1)});
                check_eq("bb_vld", {31'd0, vld_a}, 32'd1);
            end else if (ph == 10) begin
                check_eq("bb_done", {31'd0, done_a}, 32'd1);
            end else begin
                check_eq("bb_ready", {31'd0, lr_a}, 32'd1);
            end
            if (t == 33) lv_a = 1'b0;
            for (int k = 0; k < 8; k++) din_a[k] = 8'(t * 16 + k + 1);
        end
        tick();
        check_eq("bb_no_extra", {31'd0, st_a}, 32'd0);

        // 5: reset during word 3
        for (int k = 0; k < 8; k++) din_a[k] = 8'(8'hC0 + k);
        lv_a = 1'b1;
        tick();                               // E+1
        lv_a = 1'b0;
        repeat (4) tick();                    // E+5: word 3
        check_eq("ab_word3", {24'd0, do_a}, 32'hC3);
        rst = 1'b1;
        #1;
        check_eq("ab_vld", {31'd0, vld_a}, 32'd0);
        check_eq("ab_data", {24'd0, do_a}, 32'd0);
        check_eq("ab_busy", {31'd0, busy_a}, 32'd0);
        repeat (2) begin
            tick();
            check_eq("ab_no_done", {31'd0, done_a}, 32'd0);
        end
        rst = 1'b0;
        #1;
        check_eq("ab_ready", {31'd0, lr_a}, 32'd1);
        tick();
        check_eq("ab_no_done_after", {31'd0, done_a}, 32'd0);
        w = '{8'h01, 8'h80, 8'h7E, 8'hE7, 8'h3C, 8'hC3, 8'h00, 8'hFF};
        frame_a(w);

        // 6: DUT C, STAGE=1 DWIDTH=16, BEEF
        din_c[0] = 16'hBEEF;
        lv_c = 1'b1;
        tick();                               // E+1
        lv_c = 1'b0;
        din_c[0] = 16'h0000;
        check_eq("c_start", {31'd0, st_c}, 32'd1);
        check_eq("c_vld_start", {31'd0, vld_c}, 32'd0);
        tick();                               // E+2
        check_eq("c_word", {16'd0, do_c}, 32'hBEEF);
        check_eq("c_vld", {31'd0, vld_c}, 32'd1);
        tick();                               // E+3
        check_eq("c_done", {31'd0, done_c}, 32'd1);
        check_eq("c_data_done", {16'd0, do_c}, 32'd0);
        tick();
        check_eq("c_ready", {31'd0, lr_c}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
